// File: rtl/rr_stage_sequencer.sv
// Round-robin stage sequencer: enables one datapath module at a time with a
// one-cycle bus-turnaround gap, pass counting, watchdog and spurious-done detection.
module rr_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 0,
  parameter int unsigned TO_W       = 16,
  parameter int unsigned SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      in_passCount,
  input  logic [NUM_STAGES-1:0] in_doneFlags,
  output logic [NUM_STAGES-1:0] op_stageEnable,
  output logic [SEL_W-1:0]      op_activeStage,
  output logic                  op_busy,
  output logic                  op_allDone,
  output logic                  op_timeout,
  output logic                  op_spuriousDone
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STAGES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam bit               WD_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      active_nxt;
  logic [CNT_W-1:0]      passes_left, passes_nxt;
  logic                  continuous, continuous_nxt;
  logic [TO_W-1:0]       wd_cnt, wd_nxt;
  logic                  timeout_nxt, spurious_nxt;
  logic [NUM_STAGES-1:0] enable_nxt, active_mask;
  logic                  busy_nxt, all_done_nxt;
  logic                  active_done;

  // Mask form avoids indexing past NUM_STAGES when it is not a power of two
  assign active_mask = NUM_STAGES'(1) << op_activeStage;
  assign active_done = |(in_doneFlags & active_mask);

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      op_activeStage  <= '0;
      passes_left     <= '0;
      continuous      <= 1'b0;
      wd_cnt          <= '0;
      op_timeout      <= 1'b0;
      op_spuriousDone <= 1'b0;
      op_stageEnable  <= '0;
      op_busy         <= 1'b0;
      op_allDone      <= 1'b0;
    end else begin
      state           <= state_nxt;
      op_activeStage  <= active_nxt;
      passes_left     <= passes_nxt;
      continuous      <= continuous_nxt;
      wd_cnt          <= wd_nxt;
      op_timeout      <= timeout_nxt;
      op_spuriousDone <= spurious_nxt;
      op_stageEnable  <= enable_nxt;
      op_busy         <= busy_nxt;
      op_allDone      <= all_done_nxt;
    end
  end

  // Next-state, stage index, pass counter, watchdog and sticky error flags
  always_comb begin
    state_nxt      = state;
    active_nxt     = op_activeStage;
    passes_nxt     = passes_left;
    continuous_nxt = continuous;
    wd_nxt         = '0;
    timeout_nxt    = op_timeout;
    spurious_nxt   = op_spuriousDone;
    if (soft_rst) begin
      state_nxt      = IDLE;
      active_nxt     = '0;
      passes_nxt     = '0;
      continuous_nxt = 1'b0;
      timeout_nxt    = 1'b0;
      spurious_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt      = RUN;
            active_nxt     = '0;
            passes_nxt     = in_passCount;
            continuous_nxt = (in_passCount == '0);
            timeout_nxt    = 1'b0;
            spurious_nxt   = 1'b0;
          end
        end
        RUN: begin
          if (|(in_doneFlags & ~active_mask)) spurious_nxt = 1'b1;
          // A done on the watchdog's last cycle still advances normally
          if (active_done) begin
            state_nxt  = GAP;
            active_nxt = (op_activeStage == LAST_IDX) ? '0 : op_activeStage + SEL_W'(1);
            if (op_activeStage == LAST_IDX && !continuous && passes_left != '0) begin
              passes_nxt = passes_left - CNT_W'(1);
              if (passes_left == CNT_W'(1)) state_nxt = FIN;
            end
          end else if (WD_EN && wd_cnt == TO_LIMIT) begin
            state_nxt   = IDLE;
            timeout_nxt = 1'b1;
          end else begin
            wd_nxt = wd_cnt + TO_W'(1);
          end
        end
        GAP:     state_nxt = RUN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    enable_nxt   = '0;
    busy_nxt     = (state_nxt != IDLE);
    all_done_nxt = (state_nxt == FIN);
    if (state_nxt == RUN) enable_nxt = NUM_STAGES'(1) << active_nxt;
  end

endmodule

// File: tb/tb_rr_stage_sequencer.sv
// Directed bench for rr_stage_sequencer: a 2-stage continuous-capable instance
// and a 3-stage instance with a 5-cycle watchdog, plus a stage-order scoreboard.
module tb_rr_stage_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_rst2, start2, soft_rst3, start3;
  logic [7:0] cnt2, cnt3;
  logic [1:0] done2, en2;
  logic [2:0] done3, en3;
  logic [0:0] act2;
  logic [1:0] act3;
  logic       busy2, ad2, to2, sp2;
  logic       busy3, ad3, to3, sp3;

  int         checks = 0;
  int         errors = 0;
  int         ad_cnt2 = 0;
  int         ad_cnt3 = 0;
  logic [2:0] exp_q[$];
  logic [2:0] prev_en3 = '0;
  logic [2:0] e_stage;

  always #5 clock = ~clock;

  rr_stage_sequencer #(.NUM_STAGES(2), .CNT_W(8), .TIMEOUT(0), .TO_W(16)) u2 (
    .clock(clock), .reset(reset), .soft_rst(soft_rst2), .start(start2),
    .in_passCount(cnt2), .in_doneFlags(done2), .op_stageEnable(en2),
    .op_activeStage(act2), .op_busy(busy2), .op_allDone(ad2),
    .op_timeout(to2), .op_spuriousDone(sp2));

  rr_stage_sequencer #(.NUM_STAGES(3), .CNT_W(8), .TIMEOUT(5), .TO_W(16)) u3 (
    .clock(clock), .reset(reset), .soft_rst(soft_rst3), .start(start3),
    .in_passCount(cnt3), .in_doneFlags(done3), .op_stageEnable(en3),
    .op_activeStage(act3), .op_busy(busy3), .op_allDone(ad3),
    .op_timeout(to3), .op_spuriousDone(sp3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Monitor: one-hot invariant, allDone pulse counts, stage-order scoreboard
  always @(posedge clock) begin
    #1;
    check("onehot2", 32'($onehot0(en2)), 1);
    check("onehot3", 32'($onehot0(en3)), 1);
    if (ad2 === 1'b1) ad_cnt2++;
    if (ad3 === 1'b1) ad_cnt3++;
    if (en3 != 3'b000 && prev_en3 == 3'b000) begin
      if (exp_q.size() == 0) begin
        check("stage3_unexpected_rise", 32'(en3), 0);
      end else begin
        e_stage = exp_q.pop_front();
        check("stage3_order", 32'(en3), 32'(e_stage));
      end
    end
    prev_en3 = en3;
  end

  initial begin
    reset = 1'b0; soft_rst2 = 1'b0; start2 = 1'b0; soft_rst3 = 1'b0; start3 = 1'b0;
    cnt2 = '0; cnt3 = '0; done2 = '0; done3 = '0;
    #1 reset = 1'b1;
    repeat (2) step();
    check("rst_en2", 32'(en2), 0);
    check("rst_act2", 32'(act2), 0);
    check("rst_busy2", 32'(busy2), 0);
    check("rst_flags2", 32'({ad2, to2, sp2}), 0);
    check("rst_en3", 32'(en3), 0);
    check("rst_act3", 32'(act3), 0);
    check("rst_flags3", 32'({busy3, ad3, to3, sp3}), 0);
    reset = 1'b0;
    step();

    // Two stages, one pass
    cnt2 = 8'd1; start2 = 1'b1; step(); start2 = 1'b0;
    check("t1_en0", 32'(en2), 1);
    check("t1_busy", 32'(busy2), 1);
    step(); step();
    check("t1_en0_hold", 32'(en2), 1);
    done2 = 2'b01; step(); done2 = '0;
    check("t1_gap_en", 32'(en2), 0);
    check("t1_gap_act", 32'(act2), 1);
    check("t1_gap_busy", 32'(busy2), 1);
    step();
    check("t1_en1", 32'(en2), 2);
    step();
    done2 = 2'b10; step(); done2 = '0;
    check("t1_fin_ad", 32'(ad2), 1);
    check("t1_fin_en", 32'(en2), 0);
    check("t1_fin_busy", 32'(busy2), 1);
    step();
    check("t1_idle_busy", 32'(busy2), 0);
    check("t1_idle_ad", 32'(ad2), 0);
    check("t1_ad_count", ad_cnt2, 1);

    // Three stages, two passes, each stage done after two cycles
    for (int i = 0; i < 6; i++) exp_q.push_back(3'(3'b001 << (i % 3)));
    cnt3 = 8'd2; start3 = 1'b1; step(); start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      done3 = 3'(3'b001 << (i % 3)); step(); done3 = '0;
      check("t2_act", 32'(act3), (i + 1) % 3);
      step();
    end
    check("t2_idle_busy", 32'(busy3), 0);
    check("t2_ad_count", ad_cnt3, 1);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_no_errors", 32'({to3, sp3}), 0);

    // Continuous mode, 10 passes, then soft reset
    cnt2 = 8'd0; start2 = 1'b1; step(); start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      done2 = 2'(2'b01 << (i % 2)); step(); done2 = '0;
      step();
    end
    check("t3_still_run", 32'(en2), 1);
    check("t3_busy", 32'(busy2), 1);
    check("t3_no_alldone", ad_cnt2, 1);
    soft_rst2 = 1'b1; done2 = 2'b11; step(); soft_rst2 = 1'b0; done2 = '0;
    check("t3_srst_out", 32'({en2, act2, busy2, ad2, to2, sp2}), 0);
    soft_rst2 = 1'b1; start2 = 1'b1; step(); soft_rst2 = 1'b0; start2 = 1'b0;
    check("t3_srst_prio", 32'(busy2), 0);
    cnt2 = 8'd1; start2 = 1'b1; step(); start2 = 1'b0;
    check("t3_restart_en", 32'(en2), 1);
    check("t3_restart_act", 32'(act2), 0);
    soft_rst2 = 1'b1; step(); soft_rst2 = 1'b0;
    check("t3_ad_final", ad_cnt2, 1);

    // Watchdog: done on the limit cycle wins, then stage 1 times out
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    cnt3 = 8'd1; start3 = 1'b1; step(); start3 = 1'b0;
    repeat (4) step();
    check("t4_pre_limit_en", 32'(en3), 1);
    check("t4_pre_limit_to", 32'(to3), 0);
    done3 = 3'b001; step(); done3 = '0;
    check("t4_limit_done_to", 32'(to3), 0);
    check("t4_limit_done_gap", 32'({en3, busy3}), 1);
    step();
    check("t4_en1", 32'(en3), 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_wait_state", 32'({en3, to3}), 4);
    end
    step();
    check("t4_timeout", 32'(to3), 1);
    check("t4_to_idle", 32'({en3, busy3, ad3}), 0);
    step();
    check("t4_sticky", 32'(to3), 1);
    exp_q.push_back(3'b001);
    start3 = 1'b1; step(); start3 = 1'b0;
    check("t4_clear_on_start", 32'(to3), 0);
    check("t4_restart_en", 32'(en3), 1);
    soft_rst3 = 1'b1; step(); soft_rst3 = 1'b0;
    check("t4_srst_en", 32'(en3), 0);
    check("t4_ad_count", ad_cnt3, 1);
    check("t4_queue_empty", exp_q.size(), 0);

    // Spurious detection, gap masking, start while busy
    cnt2 = 8'd1; start2 = 1'b1; step(); start2 = 1'b0;
    done2 = 2'b01; step();
    check("t5_gap", 32'({en2, act2, sp2}), 2);
    step(); done2 = '0;
    check("t5_no_double_adv", 32'({en2, act2}), 5);
    check("t5_gap_not_spur", 32'(sp2), 0);
    step();
    check("t5_hold1", 32'({en2, sp2}), 4);
    done2 = 2'b11; step(); done2 = '0;
    check("t5_fin_ad", 32'(ad2), 1);
    check("t5_spur_set", 32'(sp2), 1);
    step();
    check("t5_spur_sticky", 32'({busy2, sp2}), 1);
    start2 = 1'b1; step();
    check("t5_spur_cleared", 32'(sp2), 0);
    check("t5_restart_en", 32'(en2), 1);
    step(); step(); start2 = 1'b0;
    check("t5_start_busy_ignored", 32'({en2, act2, busy2}), 5);

    // Async reset mid-cycle drops enables before the next edge
    #3 reset = 1'b1;
    #1;
    check("t6_async_en", 32'(en2), 0);
    check("t6_async_busy", 32'(busy2), 0);
    #1 reset = 1'b0;
    step();
    check("t6_post_reset", 32'({en2, busy2}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
